// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor's resolution side.
package bp_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned IDX_W = 4;

  localparam logic [15:0] SAT16_MAX = 16'hFFFF;

  // One in-flight prediction as recorded at issue time.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] index;
    logic             taken;
  } bp_entry_t;

endpackage

// File: rtl/sat_event_counter.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module sat_event_counter
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] value
);

  // Count enabled events, holding at the ceiling.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != SAT16_MAX)) begin
      value <= value + 16'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued predictions; retires them against execute-stage
// outcomes, drives the BHT/GHR update port and flushes on a mispredict.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = bp_pkg::PC_W,
  parameter int unsigned IDX_W = bp_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [IDX_W-1:0]         pred_index,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              correct_cnt,
  output logic [15:0]              mispredict_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [IDX_W-1:0] index_mem [DEPTH];
  logic             taken_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, resolve, miss, hit;

  // Ready depends only on registered occupancy, never on this cycle's resolve.
  assign pred_ready = (count_q != CNT_W'(DEPTH));
  assign count      = count_q;

  // Decode this cycle's queue operations and the next pointer/occupancy state.
  always_comb begin
    push    = pred_valid && pred_ready;
    resolve = res_valid && (count_q != '0);
    miss    = resolve && (taken_mem[head_q] != res_taken);
    hit     = resolve && !miss;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (miss) begin
      // Everything younger than the mispredicted branch is wrong-path: drop it,
      // including any prediction offered this same cycle.
      head_d  = head_q + PTR_W'(1);
      tail_d  = head_q + PTR_W'(1);
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (resolve) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(resolve);
    end
  end

  // Pointer, occupancy and registered resolution outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid     <= 1'b0;
      upd_index     <= '0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      res_err       <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      upd_valid  <= resolve;
      mispredict <= miss;
      res_err    <= res_valid && (count_q == '0);
      if (resolve) begin
        upd_index <= index_mem[head_q];
        upd_taken <= res_taken;
      end
      if (miss) begin
        mispredict_pc <= pc_mem[head_q];
      end
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !miss) begin
      pc_mem[tail_q]    <= pred_pc;
      index_mem[tail_q] <= pred_index;
      taken_mem[tail_q] <= pred_taken;
    end
  end

  sat_event_counter u_correct_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .value (correct_cnt)
  );

  sat_event_counter u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss),
    .value (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed scenarios then random traffic, compared
// against a queue-based reference model.
module tb_branch_resolve_queue;
  import bp_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [7:0]  pred_pc;
  logic [3:0]  pred_index;
  logic        pred_taken;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        mispredict;
  logic [7:0]  mispredict_pc;
  logic        res_err;
  logic [2:0]  count;
  logic [15:0] correct_cnt;
  logic [15:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .PC_W  (8),
    .IDX_W (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_index     (pred_index),
    .pred_taken     (pred_taken),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .mispredict     (mispredict),
    .mispredict_pc  (mispredict_pc),
    .res_err        (res_err),
    .count          (count),
    .correct_cnt    (correct_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bp_entry_t   mq[$];
  logic [15:0] m_cor, m_mis;
  logic        e_uv, e_ut, e_mis, e_err;
  logic [3:0]  e_ui;
  logic [7:0]  e_mpc;
  int          n_upd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock, and compare.
  task automatic step(input logic pv, input logic [7:0] pc, input logic [3:0] idx,
                      input logic pt, input logic rv, input logic rt, input logic rst);
    bp_entry_t e;
    bit ready;
    reset = rst; pred_valid = pv; pred_pc = pc; pred_index = idx; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    if (rst) begin
      mq.delete();
      m_cor = 0; m_mis = 0;
      e_uv = 0; e_ui = 0; e_ut = 0; e_mis = 0; e_mpc = 0; e_err = 0;
    end else begin
      ready = (mq.size() < DEPTH);
      e_uv  = rv && (mq.size() > 0);
      e_err = rv && (mq.size() == 0);
      e_mis = 1'b0;
      if (e_uv) begin
        e = mq.pop_front();
        e_ui = e.index;
        e_ut = rt;
        if (e.taken != rt) begin
          e_mis = 1'b1;
          e_mpc = e.pc;
          mq.delete();
          if (m_mis != 16'hFFFF) m_mis = m_mis + 1;
        end else if (m_cor != 16'hFFFF) begin
          m_cor = m_cor + 1;
        end
      end
      if (pv && ready && !e_mis) mq.push_back('{pc: pc, index: idx, taken: pt});
    end
    @(posedge clk);
    #1;
    if (upd_valid) n_upd++;
    chk("count", 32'(count), 32'(mq.size()));
    chk("pred_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
    chk("upd_valid", 32'(upd_valid), 32'(e_uv));
    chk("mispredict", 32'(mispredict), 32'(e_mis));
    chk("res_err", 32'(res_err), 32'(e_err));
    chk("correct_cnt", 32'(correct_cnt), 32'(m_cor));
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
    if (e_uv || rst) begin
      chk("upd_index", 32'(upd_index), 32'(e_ui));
      chk("upd_taken", 32'(upd_taken), 32'(e_ut));
    end
    if (e_mis || rst) chk("mispredict_pc", 32'(mispredict_pc), 32'(e_mpc));
  endtask

  initial begin
    logic [3:0] tk;
    bit pv, rv, rt, rs;
    n_upd = 0;
    m_cor = 0; m_mis = 0;
    reset = 1'b1; pred_valid = 0; pred_pc = 0; pred_index = 0; pred_taken = 0;
    res_valid = 0; res_taken = 0;
    @(posedge clk); #1;

    // Reset with stray traffic present.
    step(1, 8'hAA, 4'h5, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Fill the queue, then a refused fifth push.
    tk = 4'b0101;
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 4'(i + 3), tk[i], 0, 0, 0);
    step(1, 8'h14, 4'hF, 1, 0, 0, 0);
    // Full: push+resolve same cycle refuses the push.
    step(1, 8'h15, 4'hE, 0, 1, 1, 0);
    // Drain remaining three with matching outcomes.
    for (int i = 1; i < 4; i++) step(0, 0, 0, 0, 1, tk[i], 0);

    // Mispredict on the oldest of three, with a simultaneous dropped push.
    for (int i = 0; i < 3; i++) step(1, 8'h20 + 8'(i), 4'(i + 8), 1, 0, 0, 0);
    step(1, 8'h2F, 4'h1, 0, 1, 0, 0);

    // Resolve on empty.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Count 2, push+resolve keeps it at 2.
    step(1, 8'h30, 4'h2, 0, 0, 0, 0);
    step(1, 8'h31, 4'h3, 1, 0, 0, 0);
    step(1, 8'h32, 4'h4, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Mispredict counter saturation from a preloaded near-maximum value.
    force dut.u_mispredict_cnt.value = 16'hFFFD;
    #1;
    release dut.u_mispredict_cnt.value;
    m_mis = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h40 + 8'(i), 4'(i), 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
    end

    // Reset in the middle of a populated queue.
    step(1, 8'h50, 4'h6, 1, 0, 0, 0);
    step(1, 8'h51, 4'h7, 0, 0, 0, 0);
    step(1, 8'h52, 4'h8, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 0);

    // Random traffic with mostly-correct outcomes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0) rt = ($urandom_range(0, 5) == 0) ? !mq[0].taken : mq[0].taken;
      else rt = 1'($urandom);
      rs = ($urandom_range(0, 79) == 0);
      step(pv, 8'($urandom), 4'($urandom), 1'($urandom), rv, rt, rs);
    end

    chk("upd_strobes_seen", 32'(n_upd > 20), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Resolution-side partner of the gselect predictor: records each issued prediction (PC, BHT index, predicted direction) in an in-order queue, retires entries as actual outcomes arrive from the execute stage, and drives the BHT/GHR update port. On a mispredict it flags the branch, flushes younger in-flight predictions, and counts correct and mispredicted branches.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- PC_W, 8: branch PC width.
- IDX_W, 4: BHT index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pred_valid  in  1  new prediction offered.
- pred_pc  in  PC_W  PC of predicted branch.
- pred_index  in  IDX_W  BHT index used for the prediction.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  queue can accept (count < DEPTH).
- res_valid  in  1  oldest branch resolved this cycle.
- res_taken  in  1  actual outcome.
- upd_valid  out  1  one-cycle BHT/GHR update strobe.
- upd_index  out  IDX_W  BHT entry to update.
- upd_taken  out  1  outcome to train with.
- mispredict  out  1  one-cycle pulse, resolved direction ≠ predicted.
- mispredict_pc  out  PC_W  PC of mispredicted branch.
- res_err  out  1  one-cycle pulse, res_valid while queue empty.
- count  out  $clog2(DEPTH)+1  occupied entries.
- correct_cnt  out  16  saturating count of correct predictions.
- mispredict_cnt  out  16  saturating count of mispredictions.

## Operation
- Circular buffer, head (oldest) and tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register distinguishes full/empty.
- Push: pred_valid && pred_ready writes {pc, index, taken} at tail, tail+1.
- Resolve: res_valid && count≠0 reads head entry, head+1; registers upd_valid=1, upd_index=entry.index, upd_taken=res_taken.
- Compare entry.taken vs res_taken: equal → correct_cnt+1; differ → mispredict=1, mispredict_pc=entry.pc, mispredict_cnt+1, flush.
- Flush: all entries younger than the resolved one discarded; tail set to new head, count=0.
- Push and resolve same cycle (no mispredict): both happen, count unchanged.
- Push in a mispredict cycle: dropped (flush wins); count=0 afterwards.
- pred_ready derives from registered count only; when full, a push is refused even if a resolve happens that cycle.
- res_valid with count=0: no pop, no update, no counter change; res_err=1 next cycle.
- Counters saturate at 16'hFFFF, never wrap.
- States (implicit in count): EMPTY (count=0), PARTIAL, FULL (count=DEPTH); transitions via push (+1), resolve (−1), push+resolve (0), mispredict (→EMPTY).

## Timing
- Reset (synchronous, sampled on clk rising edge): head=tail=count=0, pred_ready=1, upd_valid=0, upd_index=0, upd_taken=0, mispredict=0, mispredict_pc=0, res_err=0, correct_cnt=mispredict_cnt=0. Queue contents don't-care.
- Reset asserted mid-operation discards all in-flight entries; no update strobe follows.
- Push-to-resolvable latency: entry pushed at edge N is resolvable at edge N+1.
- Resolve-to-update latency: 1 cycle; upd_*, mispredict, mispredict_pc, res_err registered, valid the cycle after the resolving edge.
- pred_ready and count reflect state after the most recent edge; no combinational path from res_valid or pred_valid to pred_ready.
- Back-to-back resolves every cycle supported, one update strobe per cycle.

## Structure
- Shared package bp_pkg: PC_W, IDX_W constants; bp_entry_t struct {pc, index, taken}; SAT16_MAX constant.
- One sub-module: sat_event_counter (16-bit, sync reset, inc enable, saturating), instantiated twice for correct_cnt and mispredict_cnt.

## Test plan
- Reset then push 4 entries (pc 0x10..0x13, taken 1,0,1,0) → count=4, pred_ready=0; 5th pred_valid ignored.
- Resolve all 4 with matching outcomes → four upd_valid strobes, upd_index equals pushed indices in order, correct_cnt=4, count=0, mispredict never asserted.
- Push 3 entries, resolve first with opposite outcome → mispredict=1, mispredict_pc=first pc, upd_taken=actual, count=0, mispredict_cnt=1; simultaneous push dropped.
- res_valid with empty queue → res_err pulses one cycle, no upd_valid, counters unchanged.
- Full queue with push and resolve same cycle → push refused, count=3; with count=2, push+resolve → count stays 2; 20 cycles of push/resolve exercise pointer wrap with correct order.
- Preload mispredict_cnt to 16'hFFFF via 65535 mispredicts (or forced), one more → stays 16'hFFFF; assert reset mid-stream → all outputs return to reset values next cycle.
